// File: rtl/ghash_accumulator_pkg.sv
// Shared GHASH definitions: default widths, GF(2^128) reduction constant and FSM encoding.
package ghash_accumulator_pkg;

  localparam int unsigned NB_DATA_DEF = 128;
  localparam int unsigned NB_LEN_DEF  = 64;

  // GCM reduction constant (bit 127 is x^0): 0xE1 || 0^120.
  localparam logic [127:0] R_X = {8'hE1, 120'h0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_LEN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/gf_2to128_multiplier_reg.sv
// GF(2^128) multiplier in GCM bit order; combinational path, control pins kept for compatibility.
module gf_2to128_multiplier_reg
  import ghash_accumulator_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_x,
  input  logic [NB_DATA-1:0] i_y,
  output logic [NB_DATA-1:0] o_z
);

  logic [NB_DATA-1:0] z_acc;
  logic [NB_DATA-1:0] v_sh;

  // Shift-and-add over x, MSB first; v walks y * x^i with reduction on each shift.
  always_comb begin
    z_acc = '0;
    v_sh  = i_y;
    for (int i = 0; i < int'(NB_DATA); i++) begin
      if (i_x[NB_DATA-1-i]) begin
        z_acc = z_acc ^ v_sh;
      end
      if (v_sh[0]) begin
        v_sh = (v_sh >> 1) ^ R_X;
      end else begin
        v_sh = v_sh >> 1;
      end
    end
  end

  assign o_z = z_acc;

  logic unused_ctrl;
  assign unused_ctrl = ^{i_clock, i_reset, i_valid};

endmodule

// File: rtl/ghash_accumulator.sv
// GHASH accumulator: Z <= (Z ^ block) * H over data blocks, then the length block, then present S.
module ghash_accumulator
  import ghash_accumulator_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_LEN  = NB_LEN_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_h_key,
  input  logic               i_h_load,
  input  logic               i_start,
  input  logic               i_no_data,
  input  logic [NB_LEN-1:0]  i_aad_bits,
  input  logic [NB_LEN-1:0]  i_ct_bits,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_last,
  output logic               o_ready,
  output logic [NB_DATA-1:0] o_tag,
  output logic               o_tag_valid,
  input  logic               i_tag_ready
);

  if (NB_DATA != 128 || NB_DATA != 2 * NB_LEN) begin : gen_bad_conf
    $error("BAD_CONF: NB_DATA must be 128 and equal 2*NB_LEN");
  end

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] z_q, z_d;
  logic [NB_DATA-1:0] h_q, h_d;
  logic [NB_DATA-1:0] tag_q, tag_d;
  logic [NB_LEN-1:0]  aad_q, aad_d;
  logic [NB_LEN-1:0]  ct_q, ct_d;
  logic [NB_DATA-1:0] operand;
  logic [NB_DATA-1:0] prod;

  assign operand = (state_q == ST_LEN) ? {aad_q, ct_q} : i_data;

  gf_2to128_multiplier_reg #(
    .NB_DATA (NB_DATA)
  ) u_gf_mult (
    .i_clock (i_clock),
    .i_reset (1'b0),
    .i_valid (1'b1),
    .i_x     (z_q ^ operand),
    .i_y     (h_q),
    .o_z     (prod)
  );

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    h_d         = h_q;
    tag_d       = tag_q;
    aad_d       = aad_q;
    ct_d        = ct_q;
    o_ready     = 1'b0;
    o_tag_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_h_load) begin
          h_d = i_h_key;
        end
        if (i_start) begin
          z_d     = '0;
          aad_d   = i_aad_bits;
          ct_d    = i_ct_bits;
          state_d = i_no_data ? ST_LEN : ST_DATA;
        end
      end
      ST_DATA: begin
        o_ready = 1'b1;
        if (i_valid) begin
          z_d = prod;
          if (i_last) begin
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        // Separate tag register keeps the previous S visible while the next message runs.
        z_d     = prod;
        tag_d   = prod;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        o_tag_valid = 1'b1;
        if (i_tag_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      z_q     <= '0;
      h_q     <= '0;
      tag_q   <= '0;
      aad_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      h_q     <= h_d;
      tag_q   <= tag_d;
      aad_q   <= aad_d;
      ct_q    <= ct_d;
    end
  end

  assign o_tag = tag_q;

endmodule

// File: tb/tb_ghash_accumulator.sv
// Randomized bench for ghash_accumulator against a polynomial-arithmetic GHASH model.
module tb_ghash_accumulator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] i_h_key;
  logic         i_h_load;
  logic         i_start;
  logic         i_no_data;
  logic [63:0]  i_aad_bits;
  logic [63:0]  i_ct_bits;
  logic [127:0] i_data;
  logic         i_valid;
  logic         i_last;
  logic         o_ready;
  logic [127:0] o_tag;
  logic         o_tag_valid;
  logic         i_tag_ready;

  int checks = 0;
  int errors = 0;

  logic         tag_window = 1'b0;
  logic [127:0] shown_tag  = '0;
  logic [127:0] cur_h      = '0;
  logic [127:0] blk [8];

  always #5 clk = ~clk;

  ghash_accumulator dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_h_key     (i_h_key),
    .i_h_load    (i_h_load),
    .i_start     (i_start),
    .i_no_data   (i_no_data),
    .i_aad_bits  (i_aad_bits),
    .i_ct_bits   (i_ct_bits),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_tag       (o_tag),
    .o_tag_valid (o_tag_valid),
    .i_tag_ready (i_tag_ready)
  );

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: map GCM bit order to ordinary polynomials, carry-less multiply, reduce by
  // x^128 + x^7 + x^2 + x + 1, map back.
  function automatic logic [127:0] refl(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] pa;
    logic [127:0] pb;
    logic [254:0] p;
    logic [254:0] poly;
    pa   = refl(a);
    pb   = refl(b);
    p    = '0;
    poly = (255'd1 << 128) | 255'h87;
    for (int i = 0; i < 128; i++) begin
      if (pb[i]) p = p ^ ({127'd0, pa} << i);
    end
    for (int k = 254; k >= 128; k--) begin
      if (p[k]) p = p ^ (poly << (k - 128));
    end
    return refl(p[127:0]);
  endfunction

  function automatic logic [127:0] ghash_model(input logic [127:0] h, input int n,
                                               input logic [63:0] aad, input logic [63:0] ct);
    logic [127:0] z;
    z = '0;
    for (int i = 0; i < n; i++) z = gf_mul(z ^ blk[i], h);
    return gf_mul(z ^ {aad, ct}, h);
  endfunction

  // Per-cycle output compare.
  always @(negedge clk) begin
    if (rst_n) begin
      chk1("tag_valid", o_tag_valid, tag_window);
      chk128("tag_value", o_tag, shown_tag);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_h_key     = '0;
    i_h_load    = 1'b0;
    i_start     = 1'b0;
    i_no_data   = 1'b0;
    i_aad_bits  = '0;
    i_ct_bits   = '0;
    i_data      = '0;
    i_valid     = 1'b0;
    i_last      = 1'b0;
    i_tag_ready = 1'b0;
  endtask

  task automatic noise_on();
    i_h_load   = 1'b1;
    i_h_key    = rnd128();
    i_start    = 1'b1;
    i_no_data  = 1'($urandom_range(1, 0));
    i_aad_bits = {$urandom, $urandom};
    i_ct_bits  = {$urandom, $urandom};
  endtask

  task automatic noise_off();
    i_h_load  = 1'b0;
    i_start   = 1'b0;
    i_no_data = 1'b0;
  endtask

  // load_mode: 0 = load H the cycle before start, 1 = load with start, 2 = keep current H.
  task automatic run_msg(input logic [127:0] h, input int n, input logic [63:0] aad,
                         input logic [63:0] ct, input int max_gap, input int stall,
                         input bit noise, input int load_mode, input bit use_lit,
                         input logic [127:0] lit);
    logic [127:0] exp;
    int gap;
    if (load_mode != 2) cur_h = h;
    exp = ghash_model(cur_h, n, aad, ct);
    if (use_lit) chk128("model_pin", exp, lit);
    if (load_mode == 0) begin
      i_h_key  = h;
      i_h_load = 1'b1;
      step();
      i_h_load = 1'b0;
      i_h_key  = rnd128();
    end
    chk1("ready_idle", o_ready, 1'b0);
    i_start    = 1'b1;
    i_no_data  = (n == 0);
    i_aad_bits = aad;
    i_ct_bits  = ct;
    if (load_mode == 1) begin
      i_h_load = 1'b1;
      i_h_key  = h;
    end
    step();
    noise_off();
    i_aad_bits = {$urandom, $urandom};
    i_ct_bits  = {$urandom, $urandom};
    for (int b = 0; b < n; b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        i_valid = 1'b0;
        i_last  = 1'($urandom_range(1, 0));
        i_data  = rnd128();
        if (noise) noise_on();
        chk1("ready_bubble", o_ready, 1'b1);
        step();
        noise_off();
      end
      chk1("ready_data", o_ready, 1'b1);
      i_valid = 1'b1;
      i_data  = blk[b];
      i_last  = (b == n - 1);
      if (noise && b == 0) noise_on();
      step();
      noise_off();
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_data  = rnd128();
    end
    chk1("ready_len", o_ready, 1'b0);
    step();
    tag_window = 1'b1;
    shown_tag  = exp;
    if (use_lit) chk128("tag_literal", o_tag, lit);
    for (int s = 0; s < stall; s++) begin
      if (noise) noise_on();
      chk1("ready_done", o_ready, 1'b0);
      step();
      noise_off();
    end
    i_tag_ready = 1'b1;
    step();
    i_tag_ready = 1'b0;
    tag_window  = 1'b0;
  endtask

  logic [127:0] h_tc;
  logic [127:0] d_id;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk1("reset_ready", o_ready, 1'b0);
    chk1("reset_tag_valid", o_tag_valid, 1'b0);
    chk128("reset_tag", o_tag, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // GCM test case 1: empty message.
    h_tc = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    run_msg(h_tc, 0, 64'd0, 64'd0, 0, 0, 1'b0, 0, 1'b1, 128'h0);

    // Identity H: S = D ^ length block.
    d_id   = 128'h0123456789abcdeffedcba9876543210;
    blk[0] = d_id;
    run_msg(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1, 64'd0, 64'd128, 0, 0, 1'b0, 0,
            1'b1, d_id ^ {64'd0, 64'd128});

    // GCM test case 2.
    blk[0] = 128'h0388dace60b6a392f328c2b971b2fe78;
    run_msg(h_tc, 1, 64'd0, 64'd128, 0, 0, 1'b0, 0, 1'b1,
            128'hf38cbb1ad69223dcc3457ae5b6b0f885);

    // Four blocks gapless, then with bubbles and a stalled tag handshake.
    for (int i = 0; i < 4; i++) blk[i] = rnd128();
    h_tc = rnd128();
    run_msg(h_tc, 4, 64'd256, 64'd256, 0, 0, 1'b0, 0, 1'b0, '0);
    run_msg(h_tc, 4, 64'd256, 64'd256, 3, 5, 1'b0, 2, 1'b0, '0);

    // Ignored h_load/start in DATA and DONE, then reuse H; then load together with start.
    for (int i = 0; i < 3; i++) blk[i] = rnd128();
    run_msg(rnd128(), 3, 64'd100, 64'd284, 2, 3, 1'b1, 0, 1'b0, '0);
    run_msg('0, 2, 64'd0, 64'd256, 1, 1, 1'b0, 2, 1'b0, '0);
    run_msg(rnd128(), 2, 64'd7, 64'd200, 0, 1, 1'b0, 1, 1'b0, '0);

    // Randomized messages.
    for (int m = 0; m < 25; m++) begin
      int n;
      n = int'($urandom_range(6, 0));
      for (int i = 0; i < 8; i++) blk[i] = rnd128();
      run_msg(rnd128(), n, {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
              1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), 1'b0, '0);
    end

    // Async reset in the middle of a message.
    i_h_key  = rnd128();
    i_h_load = 1'b1;
    step();
    i_h_load  = 1'b0;
    i_start   = 1'b1;
    step();
    i_start   = 1'b0;
    i_valid   = 1'b1;
    i_data    = rnd128();
    step();
    step();
    i_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_ready", o_ready, 1'b0);
    chk1("async_tag_valid", o_tag_valid, 1'b0);
    chk128("async_tag", o_tag, 128'h0);
    shown_tag  = '0;
    tag_window = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // H cleared by reset: reuse-H message hashes to zero.
    cur_h  = '0;
    blk[0] = rnd128();
    run_msg('0, 1, 64'd0, 64'd128, 0, 0, 1'b0, 2, 1'b0, '0);
    blk[0] = rnd128();
    run_msg(rnd128(), 1, 64'd0, 64'd128, 0, 2, 1'b0, 0, 1'b0, '0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
